// File: rtl/strip_chart_pkg.sv
// strip_chart_pkg: shared state encoding, colours and ring addressing for the strip-chart renderer
package strip_chart_pkg;
  typedef logic [2:0] state_t;
  localparam state_t S_INIT_RING = 3'd0;
  localparam state_t S_INIT_PLOT = 3'd1;
  localparam state_t S_IDLE      = 3'd2;
  localparam state_t S_WR_SAMPLE = 3'd3;
  localparam state_t S_RD_ENTRY  = 3'd4;
  localparam state_t S_PIX_ROW   = 3'd5;
  localparam state_t S_NEXT_ROW  = 3'd6;
  localparam state_t S_PUBLISH   = 3'd7;
  localparam logic [15:0] RGB_BLACK   = 16'h0000;
  localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
  function automatic logic [23:0] ring_addr(input logic [23:0] base, input logic [15:0] idx);
    return base + {6'd0, idx, 2'b00};
  endfunction
endpackage

// File: rtl/strip_chart_burst_port.sv
// strip_chart_burst_port: single req/done sequencer for 4-word read and write bursts
module strip_chart_burst_port (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             i_start,
  input  logic             i_write,
  input  logic [23:0]      i_addr,
  input  logic [3:0][15:0] i_data,
  input  logic             i_rd_done,
  input  logic             i_wr_done,
  output logic             o_rd_req,
  output logic             o_wr_req,
  output logic [23:0]      o_addr,
  output logic [3:0][15:0] o_data,
  output logic             o_idle,
  output logic             o_done
);
  logic rd_req_q, rd_req_d, wr_req_q, wr_req_d, launch;
  logic [23:0] addr_q, addr_d;
  logic [3:0][15:0] data_q, data_d;
  assign o_idle = !rd_req_q && !wr_req_q;
  assign o_done = (rd_req_q && i_rd_done) || (wr_req_q && i_wr_done);
  assign launch = o_idle && i_start;
  // a single launch point keeps read and write requests mutually exclusive
  always_comb begin
    rd_req_d = en && (o_done ? 1'b0 : rd_req_q || (launch && !i_write));
    wr_req_d = en && (o_done ? 1'b0 : wr_req_q || (launch && i_write));
    addr_d = !en ? '0 : launch ? i_addr : addr_q;
    data_d = !en ? '0 : (launch && i_write) ? i_data : data_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_req_q <= 1'b0;
      wr_req_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      rd_req_q <= rd_req_d;
      wr_req_q <= wr_req_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end
  assign o_rd_req = rd_req_q;
  assign o_wr_req = wr_req_q;
  assign o_addr = addr_q;
  assign o_data = data_q;
endmodule

// File: rtl/strip_chart_renderer.sv
// strip_chart_renderer: SDRAM ring of recent samples redrawn into LCD GRAM once per accepted sample
module strip_chart_renderer import strip_chart_pkg::*; #(
  parameter int N_POINTS = 600,
  parameter int PLOT_X0 = 12,
  parameter int PLOT_W = 220,
  parameter int PLOT_Y0 = 15,
  parameter int LINE_PITCH = 480,
  parameter int RING_BASE = 384000,
  parameter int DATA_W = 16,
  parameter int METRIC_W = 32,
  parameter logic [15:0] FG_COLOR = RGB_MAGENTA,
  parameter logic [15:0] BG_COLOR = RGB_BLACK
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                i_sample_valid,
  output logic                o_sample_ready,
  input  logic [DATA_W-1:0]   i_sample,
  input  logic [METRIC_W-1:0] i_metric,
  input  logic [2:0]          i_gain_shift,
  input  logic                i_mode,
  output logic                o_rd_req,
  input  logic                i_rd_done,
  output logic [23:0]         o_rd_addr,
  input  logic [15:0]         i_rd_data1,
  input  logic [15:0]         i_rd_data2,
  input  logic [15:0]         i_rd_data3,
  input  logic [15:0]         i_rd_data4,
  output logic                o_wr_req,
  input  logic                i_wr_done,
  output logic [23:0]         o_wr_addr,
  output logic [15:0]         o_wr_data1,
  output logic [15:0]         o_wr_data2,
  output logic [15:0]         o_wr_data3,
  output logic [15:0]         o_wr_data4,
  output logic [METRIC_W-1:0] o_max,
  output logic [METRIC_W-1:0] o_min,
  output logic                o_frame_done,
  output logic                o_busy
);
  localparam int IW = $clog2(N_POINTS + 1);
  localparam int GW = $clog2(PLOT_W / 4 + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_POINTS - 1);
  localparam logic [GW-1:0] LAST_GRP = GW'(PLOT_W / 4 - 1);
  localparam logic [23:0] ROW0 = 24'(PLOT_Y0 * LINE_PITCH + PLOT_X0);
  localparam logic [23:0] BASE = 24'(RING_BASE);
  typedef struct packed {
    state_t              state;
    logic [IW-1:0]       head, idx, rd_idx;
    logic [GW-1:0]       grp;
    logic [23:0]         row;
    logic [15:0]         sample, len;
    logic [47:0]         metric;
    logic [2:0]          gain;
    logic                mode;
    logic [METRIC_W-1:0] mx_acc, mn_acc, mx, mn;
    logic                done, ready, busy;
  } ctx_t;
  localparam ctx_t CTX_RST = '{state: S_INIT_RING, mn_acc: '1, mn: '1, default: '0};
  ctx_t ctx_q, ctx_d, nxt;
  logic port_idle, port_done, start, write, unused_ok;
  logic [23:0] addr, port_addr;
  logic [3:0][15:0] wdata, pix, port_data;
  logic [47:0] rd_m48;
  logic [METRIC_W-1:0] rd_m;
  logic [15:0] shifted, rd_len, p;
  function automatic logic [IW-1:0] inc(input logic [IW-1:0] x);
    return x == LAST_IDX ? '0 : x + IW'(1);
  endfunction
  always_comb begin
    rd_m48 = {i_rd_data2, i_rd_data3, i_rd_data4};
    rd_m = rd_m48[METRIC_W-1:0];
    shifted = i_rd_data1 >> ctx_q.gain;
    rd_len = shifted > 16'(PLOT_W) ? 16'(PLOT_W) : shifted;
    p = '0;
    pix = '0;
    for (int k = 0; k < 4; k++) begin
      p = 16'({ctx_q.grp, 2'b00}) + 16'(k);
      pix[k] = (ctx_q.mode ? (ctx_q.len != '0 && p == ctx_q.len - 16'd1) : p < ctx_q.len) ? FG_COLOR : BG_COLOR;
    end
    wdata = ctx_q.state == S_INIT_RING ? '0 :
            ctx_q.state == S_INIT_PLOT ? {4{BG_COLOR}} :
            ctx_q.state == S_WR_SAMPLE ? {ctx_q.metric[15:0], ctx_q.metric[31:16], ctx_q.metric[47:32], ctx_q.sample} : pix;
    addr = ctx_q.state == S_INIT_RING ? ring_addr(BASE, 16'(ctx_q.idx)) :
           ctx_q.state == S_WR_SAMPLE ? ring_addr(BASE, 16'(ctx_q.head)) :
           ctx_q.state == S_RD_ENTRY  ? ring_addr(BASE, 16'(ctx_q.rd_idx)) : ctx_q.row + 24'({ctx_q.grp, 2'b00});
    start = ctx_q.state inside {S_INIT_RING, S_INIT_PLOT, S_WR_SAMPLE, S_RD_ENTRY, S_PIX_ROW};
    write = ctx_q.state != S_RD_ENTRY;
  end
  always_comb begin
    nxt = ctx_q;
    nxt.done = 1'b0;
    case (ctx_q.state)
      S_INIT_RING: if (port_done) begin
        nxt.idx = inc(ctx_q.idx);
        if (ctx_q.idx == LAST_IDX) begin
          nxt.state = S_INIT_PLOT;
          nxt.row = ROW0;
          nxt.grp = '0;
        end
      end
      S_INIT_PLOT: if (port_done) begin
        nxt.grp = ctx_q.grp == LAST_GRP ? '0 : ctx_q.grp + GW'(1);
        if (ctx_q.grp == LAST_GRP) begin
          nxt.row = ctx_q.row + 24'(LINE_PITCH);
          nxt.idx = inc(ctx_q.idx);
          nxt.state = ctx_q.idx == LAST_IDX ? S_IDLE : S_INIT_PLOT;
        end
      end
      S_IDLE: if (i_sample_valid && ctx_q.ready) begin
        nxt.sample = 16'(i_sample);
        nxt.metric = 48'(i_metric);
        nxt.gain = i_gain_shift;
        nxt.mode = i_mode;
        nxt.mx_acc = '0;
        nxt.mn_acc = '1;
        nxt.state = S_WR_SAMPLE;
      end
      S_WR_SAMPLE: if (port_done) begin
        nxt.rd_idx = inc(ctx_q.head);
        nxt.idx = '0;
        nxt.row = ROW0;
        nxt.state = S_RD_ENTRY;
      end
      S_RD_ENTRY: if (port_done) begin
        nxt.len = rd_len;
        nxt.mx_acc = rd_m > ctx_q.mx_acc ? rd_m : ctx_q.mx_acc;
        nxt.mn_acc = rd_m < ctx_q.mn_acc ? rd_m : ctx_q.mn_acc;
        nxt.grp = '0;
        nxt.state = S_PIX_ROW;
      end
      S_PIX_ROW: if (port_done) begin
        nxt.grp = ctx_q.grp + GW'(1);
        nxt.state = ctx_q.grp == LAST_GRP ? S_NEXT_ROW : S_PIX_ROW;
      end
      S_NEXT_ROW: begin
        nxt.row = ctx_q.row + 24'(LINE_PITCH);
        nxt.rd_idx = inc(ctx_q.rd_idx);
        nxt.idx = inc(ctx_q.idx);
        nxt.state = ctx_q.idx == LAST_IDX ? S_PUBLISH : S_RD_ENTRY;
      end
      S_PUBLISH: begin
        nxt.mx = ctx_q.mx_acc;
        nxt.mn = ctx_q.mn_acc;
        nxt.done = 1'b1;
        nxt.head = inc(ctx_q.head);
        nxt.state = S_IDLE;
      end
      default: nxt.state = S_INIT_RING;
    endcase
    // ready trails frame_done by one cycle so the producer sees fresh extremes first
    nxt.ready = nxt.state == S_IDLE && !nxt.done;
    nxt.busy = nxt.state != S_IDLE;
    ctx_d = en ? nxt : CTX_RST;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ctx_q <= CTX_RST;
    else ctx_q <= ctx_d;
  end
  strip_chart_burst_port u_port (
    .clk(clk), .rst_n(rst_n), .en(en),
    .i_start(start), .i_write(write), .i_addr(addr), .i_data(wdata),
    .i_rd_done(i_rd_done), .i_wr_done(i_wr_done),
    .o_rd_req(o_rd_req), .o_wr_req(o_wr_req), .o_addr(port_addr), .o_data(port_data),
    .o_idle(port_idle), .o_done(port_done)
  );
  assign unused_ok = ^{rd_m48, port_idle};
  assign o_rd_addr = port_addr;
  assign o_wr_addr = port_addr;
  assign o_wr_data1 = port_data[0];
  assign o_wr_data2 = port_data[1];
  assign o_wr_data3 = port_data[2];
  assign o_wr_data4 = port_data[3];
  assign o_sample_ready = ctx_q.ready;
  assign o_busy = ctx_q.busy;
  assign o_frame_done = ctx_q.done;
  assign o_max = ctx_q.mx;
  assign o_min = ctx_q.mn;
endmodule

// File: tb/tb_strip_chart_renderer.sv
// tb_strip_chart_renderer: random and directed frames checked against a sample-history model
module tb_strip_chart_renderer;
  localparam int N = 5, X0 = 4, W = 12, Y0 = 2, LP = 20, RB = 400, MW = 40;
  localparam logic [15:0] FG = 16'hF81F, BG = 16'h001F;
  logic clk = 0, rst_n = 0, en = 1;
  logic i_sample_valid = 0, i_mode = 0;
  logic [15:0] i_sample = 0;
  logic [MW-1:0] i_metric = 0;
  logic [2:0] i_gain_shift = 0;
  logic i_rd_done = 0, i_wr_done = 0;
  logic [15:0] i_rd_data1 = 0, i_rd_data2 = 0, i_rd_data3 = 0, i_rd_data4 = 0;
  logic o_sample_ready, o_rd_req, o_wr_req, o_frame_done, o_busy;
  logic [23:0] o_rd_addr, o_wr_addr;
  logic [15:0] o_wr_data1, o_wr_data2, o_wr_data3, o_wr_data4;
  logic [MW-1:0] o_max, o_min;
  always #5 clk = ~clk;
  strip_chart_renderer #(
    .N_POINTS(N), .PLOT_X0(X0), .PLOT_W(W), .PLOT_Y0(Y0), .LINE_PITCH(LP),
    .RING_BASE(RB), .DATA_W(16), .METRIC_W(MW), .FG_COLOR(FG), .BG_COLOR(BG)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .i_sample_valid(i_sample_valid), .o_sample_ready(o_sample_ready),
    .i_sample(i_sample), .i_metric(i_metric), .i_gain_shift(i_gain_shift), .i_mode(i_mode),
    .o_rd_req(o_rd_req), .i_rd_done(i_rd_done), .o_rd_addr(o_rd_addr),
    .i_rd_data1(i_rd_data1), .i_rd_data2(i_rd_data2), .i_rd_data3(i_rd_data3), .i_rd_data4(i_rd_data4),
    .o_wr_req(o_wr_req), .i_wr_done(i_wr_done), .o_wr_addr(o_wr_addr),
    .o_wr_data1(o_wr_data1), .o_wr_data2(o_wr_data2), .o_wr_data3(o_wr_data3), .o_wr_data4(o_wr_data4),
    .o_max(o_max), .o_min(o_min), .o_frame_done(o_frame_done), .o_busy(o_busy)
  );
  int tests = 0, fails = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  typedef struct { int s; logic [MW-1:0] m; } ent_t;
  ent_t hist[$];
  bit [15:0] mem [int];
  int ring_wr = 0, ring_nz = 0, plot_wr = 0, plot_nbg = 0, wait_c = 0;
  bit seen = 0;
  logic [23:0] cap_addr;
  logic [63:0] cap_data, wd;
  // memory responder: random 0..2 cycle latency, occasional stray done while idle
  always @(negedge clk) begin
    i_rd_done = 0;
    i_wr_done = 0;
    check("mutex", 64'(o_rd_req && o_wr_req), 64'd0);
    wd = {o_wr_data4, o_wr_data3, o_wr_data2, o_wr_data1};
    if (o_rd_req || o_wr_req) begin
      if (!seen) begin
        seen = 1;
        wait_c = $urandom_range(0, 2);
        cap_addr = o_wr_req ? o_wr_addr : o_rd_addr;
        cap_data = wd;
      end else begin
        check("hold_addr", 64'(o_wr_req ? o_wr_addr : o_rd_addr), 64'(cap_addr));
        if (o_wr_req) check("hold_data", wd, cap_data);
      end
      if (wait_c == 0) begin
        if (o_wr_req) begin
          for (int k = 0; k < 4; k++) mem[int'(o_wr_addr) + k] = wd[16*k +: 16];
          if (int'(o_wr_addr) >= RB) begin
            ring_wr++;
            if (wd != 0) ring_nz++;
          end else begin
            plot_wr++;
            if (wd != {4{BG}}) plot_nbg++;
          end
          i_wr_done = 1;
        end else begin
          i_rd_data1 = mem[int'(o_rd_addr)];
          i_rd_data2 = mem[int'(o_rd_addr) + 1];
          i_rd_data3 = mem[int'(o_rd_addr) + 2];
          i_rd_data4 = mem[int'(o_rd_addr) + 3];
          i_rd_done = 1;
        end
        seen = 0;
      end else wait_c--;
    end else begin
      seen = 0;
      if ($urandom_range(0, 7) == 0) begin
        i_rd_done = 1;
        i_wr_done = 1;
      end
    end
  end
  task automatic reset_model();
    ent_t e;
    e.s = 0;
    e.m = '0;
    hist.delete();
    for (int i = 0; i < N; i++) hist.push_back(e);
  endtask
  task automatic wait_ready();
    int t = 0;
    while (!o_sample_ready && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check("ready", 64'(o_sample_ready), 64'd1);
  endtask
  task automatic check_frame(input int gain, input bit mode);
    logic [MW-1:0] mx, mn;
    logic [63:0] got, exp;
    int l, a, p;
    mx = '0;
    mn = '1;
    for (int r = 0; r < N; r++) begin
      l = hist[r].s >> gain;
      if (l > W) l = W;
      if (hist[r].m > mx) mx = hist[r].m;
      if (hist[r].m < mn) mn = hist[r].m;
      for (int g = 0; g < W / 4; g++) begin
        a = (Y0 + r) * LP + X0 + 4 * g;
        for (int k = 0; k < 4; k++) begin
          p = 4 * g + k;
          got[16*k +: 16] = mem[a + k];
          exp[16*k +: 16] = (mode ? (l > 0 && p == l - 1) : (p < l)) ? FG : BG;
        end
        check($sformatf("pix r%0d g%0d", r, g), got, exp);
      end
    end
    check("max", 64'(o_max), 64'(mx));
    check("min", 64'(o_min), 64'(mn));
  endtask
  task automatic send(input int s, input logic [MW-1:0] m, input int gain, input bit mode);
    ent_t e;
    logic [63:0] r;
    int t;
    wait_ready();
    i_sample = 16'(s);
    i_metric = m;
    i_gain_shift = 3'(gain);
    i_mode = mode;
    i_sample_valid = 1;
    @(negedge clk);
    i_sample_valid = 0;
    r = {$urandom, $urandom};
    i_sample = r[15:0];
    i_gain_shift = r[18:16];
    i_mode = r[20];
    i_metric = r[MW-1:0];
    check("busy", 64'(o_busy), 64'd1);
    check("ready_busy", 64'(o_sample_ready), 64'd0);
    e.s = s;
    e.m = m;
    hist.push_back(e);
    void'(hist.pop_front());
    t = 0;
    while (!o_frame_done && t < 20000) begin
      @(negedge clk);
      t++;
    end
    check("frame_done", 64'(o_frame_done), 64'd1);
    check("ready_at_fd", 64'(o_sample_ready), 64'd0);
    @(negedge clk);
    check("fd_pulse", 64'(o_frame_done), 64'd0);
    check("ready_after", 64'(o_sample_ready), 64'd1);
    check_frame(gain, mode);
  endtask
  initial begin
    int b_rw, b_rn, b_pw, b_pn, t;
    logic [63:0] r;
    reset_model();
    repeat (3) @(negedge clk);
    check("rst_wr_req", 64'(o_wr_req), 64'd0);
    check("rst_rd_req", 64'(o_rd_req), 64'd0);
    check("rst_ready", 64'(o_sample_ready), 64'd0);
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_fd", 64'(o_frame_done), 64'd0);
    check("rst_max", 64'(o_max), 64'd0);
    check("rst_min", 64'(o_min), 64'({MW{1'b1}}));
    rst_n = 1;
    wait_ready();
    check("init_ring_wr", 64'(ring_wr), 64'(N));
    check("init_ring_nz", 64'(ring_nz), 64'd0);
    check("init_plot_wr", 64'(plot_wr), 64'(N * W / 4));
    check("init_plot_nbg", 64'(plot_nbg), 64'd0);
    check("init_min", 64'(o_min), 64'({MW{1'b1}}));
    send(7, 40'd11, 0, 0);
    send(1000, 40'hFF_0000_0001, 2, 0);
    send(5, 40'd3, 0, 1);
    send(0, 40'd9, 0, 1);
    send(12, 40'd4, 0, 1);
    send(24, 40'd8, 1, 0);
    for (int i = 0; i < 8; i++) begin
      r = {$urandom, $urandom};
      send(i[0] ? $urandom_range(0, 20) : $urandom_range(0, 65535), r[MW-1:0], $urandom_range(0, 7), 1'($urandom_range(0, 1)));
    end
    wait_ready();
    i_sample = 16'd9;
    i_sample_valid = 1;
    @(negedge clk);
    i_sample_valid = 0;
    t = 0;
    while (!o_wr_req && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("drop_wr_req_seen", 64'(o_wr_req), 64'd1);
    en = 0;
    @(negedge clk);
    check("drop_wr_req", 64'(o_wr_req), 64'd0);
    check("drop_rd_req", 64'(o_rd_req), 64'd0);
    check("drop_min", 64'(o_min), 64'({MW{1'b1}}));
    check("drop_max", 64'(o_max), 64'd0);
    en = 1;
    b_rw = ring_wr;
    b_rn = ring_nz;
    b_pw = plot_wr;
    b_pn = plot_nbg;
    reset_model();
    @(negedge clk);
    check("restart_busy", 64'(o_busy), 64'd1);
    wait_ready();
    check("reinit_ring_wr", 64'(ring_wr - b_rw), 64'(N));
    check("reinit_ring_nz", 64'(ring_nz - b_rn), 64'd0);
    check("reinit_plot_wr", 64'(plot_wr - b_pw), 64'(N * W / 4));
    check("reinit_plot_nbg", 64'(plot_nbg - b_pn), 64'd0);
    for (int i = 1; i <= N + 1; i++) send(i, 40'(i), 0, 0);
    check("wrap_max", 64'(o_max), 64'(N + 1));
    check("wrap_min", 64'(o_min), 64'd2);
    check("wrap_ring0", 64'(mem[RB]), 64'(N + 1));
    check("wrap_ring1", 64'(mem[RB + 4]), 64'd2);
    check("wrap_row0", {mem[Y0*LP+X0+3], mem[Y0*LP+X0+2], mem[Y0*LP+X0+1], mem[Y0*LP+X0]}, {BG, BG, FG, FG});
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
